memory_cycle: RTL
=================

// Module: memory_cycle
// PURPOSE
// - MEM stage of the 5-stage RISC-V pipeline; consumes the EX/MEM register outputs (MEM_*), drives the data bus.
// - Performs byte/half/word loads and stores through a req/ack handshake and stalls upstream while busy.
// - Registers results into MEM/WB (WB_*) for the writeback stage.
// PARAMETERS
// - TIMEOUT_CYC  16  max cycles dmem_req_o waits for ack before abort (>=2)
// PORTS
// - clk_i          in   1   clock; all state updates on rising edge
// - rst_i          in   1   synchronous reset, active-high
// - MEM_alu_data   in   32  effective address (ld/st) or ALU result
// - MEM_rs2_data   in   32  store data
// - MEM_pc_four    in   32  PC+4, passed through
// - MEM_rd_addr    in   5   destination register
// - MEM_rd_wren    in   1   register write enable
// - MEM_mem_en     in   9   one-hot op: [0]sb [1]sh [2]sw [3]lb [4]lh [5]lw [6]lbu [7]lhu; [8] reserved, ignored
// - MEM_wb_en      in   2   writeback select, passed through
// - dmem_req_o     out  1   bus request, held until ack or timeout
// - dmem_we_o      out  1   1 = store
// - dmem_addr_o    out  32  word address {MEM_alu_data[31:2],2'b00}
// - dmem_be_o      out  4   byte enables
// - dmem_wdata_o   out  32  lane-replicated store data
// - dmem_ack_i     in   1   one-cycle completion; dmem_rdata_i valid same cycle
// - dmem_rdata_i   in   32  load data word
// - MEM_stall_o    out  1   combinational; 1 = hold EX/MEM register and earlier stages
// - WB_alu_data / WB_ld_data / WB_pc_four  out 32  registered results
// - WB_rd_addr out 5, WB_rd_wren out 1, WB_wb_en out 2   registered control
// - misalign_o     out  1   one-cycle pulse, misaligned access dropped
// - bus_err_o      out  1   one-cycle pulse, access aborted by timeout
// BEHAVIOUR
// - Reset: state IDLE; every registered output, dmem_* and pulses = 0; MEM_stall_o = 0.
// - FSM IDLE/BUS. access = exactly one of MEM_mem_en[7:0] set; >1 bit set is treated as no access.
// - IDLE, no access: WB_* <= MEM_*, WB_ld_data <= 0; latency 1; stall 0.
// - IDLE, misaligned access (lh/lhu/sh addr[0]=1; lw/sw addr[1:0]!=0): no request; misalign_o pulses next
//   cycle; WB_rd_wren <= 0, other WB_* pass through; stall 0.
// - IDLE, aligned access: MEM_stall_o=1 this cycle; next edge -> BUS, dmem_* registered, timeout counter cleared;
//   WB_rd_wren <= 0 (bubble).
// - BUS: dmem_* constant; counter increments each cycle. MEM_stall_o = ~dmem_ack_i & ~timeout.
//   ack: WB_* <= MEM_*, WB_ld_data <= formatted dmem_rdata_i (0 for stores), -> IDLE, req drops next edge.
//   counter == TIMEOUT_CYC-1 without ack: abort, bus_err_o pulse, WB_rd_wren <= 0, -> IDLE.
//   Ack in the timeout cycle counts as success.
//   Other BUS cycles: WB_rd_wren <= 0.
// - Minimum load/store latency 2 cycles (ack in first BUS cycle); stall asserted exactly latency-1 cycles.
// - Stores: sb be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; sh be=4'b0011<<{addr[1],1'b0},
//   wdata={2{rs2[15:0]}}; sw be=4'hF, wdata=rs2.
// - Loads: byte lane addr[1:0], half lane addr[1]; lb/lh sign-extend, lbu/lhu zero-extend; lw unchanged.
// - rst_i in BUS: next edge IDLE, dmem_req_o=0; a late ack is ignored.
// - dmem_ack_i in IDLE is ignored.
// STRUCTURE
// - riscv_pkg: MEM_EN_SB..MEM_EN_LHU bit-index localparams, mem_state_e {IDLE,BUS}, lsu_op_e decode.
// - Sub-module lsu_load_align (combinational): rdata, addr[1:0], op -> 32-bit formatted load data.
// - Top: decode/align check, FSM, timeout counter, bus regs, MEM/WB regs.
// TESTING
// - sw addr 0x104 data 0xDEADBEEF, ack 1st BUS cycle -> be=F, addr 0x104, stall 1 cycle, WB_rd_wren=0.
// - lb addr 0x203, rdata 0x80FF_0000 -> be=8, WB_ld_data=0xFFFFFF80; lbu same -> 0x00000080.
// - sh addr 0x102 data 0x1234 -> be=4'b1100, wdata 0x12341234; lh addr 0x101 -> misalign_o, no req.
// - lw, ack withheld -> stall held 15 cycles, bus_err_o on 16th, WB_rd_wren=0, back to IDLE.
// - add (mem_en=0) rd=5 alu 0x55 -> WB_alu_data=0x55, WB_rd_wren=1 next cycle, stall never asserted.
// - rst_i during BUS of lw -> req drops next edge, all outputs 0; later ack causes no WB write.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store definitions for the MEM stage: op-select bit indices,
// FSM states and the one-hot op decode helpers.
package riscv_pkg;

  localparam int unsigned MEM_EN_SB  = 0;
  localparam int unsigned MEM_EN_SH  = 1;
  localparam int unsigned MEM_EN_SW  = 2;
  localparam int unsigned MEM_EN_LB  = 3;
  localparam int unsigned MEM_EN_LH  = 4;
  localparam int unsigned MEM_EN_LW  = 5;
  localparam int unsigned MEM_EN_LBU = 6;
  localparam int unsigned MEM_EN_LHU = 7;

  typedef enum logic {
    IDLE,
    BUS
  } mem_state_e;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_SB,
    OP_SH,
    OP_SW,
    OP_LB,
    OP_LH,
    OP_LW,
    OP_LBU,
    OP_LHU
  } lsu_op_e;

  // Bit 8 is a don't-care; anything other than exactly one of [7:0] is no access.
  function automatic lsu_op_e lsu_decode(input logic [8:0] mem_en);
    lsu_op_e op;
    op = OP_NONE;
    casez (mem_en)
      9'b?0000_0001: op = OP_SB;
      9'b?0000_0010: op = OP_SH;
      9'b?0000_0100: op = OP_SW;
      9'b?0000_1000: op = OP_LB;
      9'b?0001_0000: op = OP_LH;
      9'b?0010_0000: op = OP_LW;
      9'b?0100_0000: op = OP_LBU;
      9'b?1000_0000: op = OP_LHU;
      default:       op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic lsu_is_store(input lsu_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic lsu_misaligned(input lsu_op_e op, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_SH, OP_LH, OP_LHU: mis = addr_lo[0];
      OP_SW, OP_LW:         mis = (addr_lo != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter: selects the byte/half lane from the bus word and
// sign- or zero-extends it; non-load ops return zero.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  lsu_op_e     op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (op_i)
      OP_LB:   data_o = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  data_o = {24'h0, byte_v};
      OP_LH:   data_o = {{16{half_v[15]}}, half_v};
      OP_LHU:  data_o = {16'h0, half_v};
      OP_LW:   data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// MEM pipeline stage: issues byte/half/word loads and stores over a req/ack
// bus with timeout, stalls upstream while busy and registers MEM/WB results.
module memory_cycle
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] MEM_alu_data,
  input  logic [31:0] MEM_rs2_data,
  input  logic [31:0] MEM_pc_four,
  input  logic [4:0]  MEM_rd_addr,
  input  logic        MEM_rd_wren,
  input  logic [8:0]  MEM_mem_en,
  input  logic [1:0]  MEM_wb_en,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        MEM_stall_o,
  output logic [31:0] WB_alu_data,
  output logic [31:0] WB_ld_data,
  output logic [31:0] WB_pc_four,
  output logic [4:0]  WB_rd_addr,
  output logic        WB_rd_wren,
  output logic [1:0]  WB_wb_en,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lsu_op_e          op_q, op_d;
  logic [1:0]       lane_q, lane_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_ld_q, wb_ld_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic        wb_rd_wren_q, wb_rd_wren_d;
  logic [1:0]  wb_wb_en_q, wb_wb_en_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  lsu_op_e     op;
  logic        misaligned;
  logic        timeout;
  logic        stall;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ld_fmt;

  assign op         = lsu_decode(MEM_mem_en);
  assign misaligned = lsu_misaligned(op, MEM_alu_data[1:0]);
  assign timeout    = (state_q == BUS) && (cnt_q == CNT_LAST);

  // Op and lane are captured at issue so formatting does not depend on upstream holding.
  lsu_load_align u_load_align (
    .rdata_i (dmem_rdata_i),
    .addr_i  (lane_q),
    .op_i    (op_q),
    .data_o  (ld_fmt)
  );

  always_comb begin
    case (op)
      OP_SB, OP_LB, OP_LBU: be_new = 4'b0001 << MEM_alu_data[1:0];
      OP_SH, OP_LH, OP_LHU: be_new = 4'b0011 << {MEM_alu_data[1], 1'b0};
      OP_SW, OP_LW:         be_new = 4'hF;
      default:              be_new = '0;
    endcase
    case (op)
      OP_SB:   wdata_new = {4{MEM_rs2_data[7:0]}};
      OP_SH:   wdata_new = {2{MEM_rs2_data[15:0]}};
      OP_SW:   wdata_new = MEM_rs2_data;
      default: wdata_new = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    lane_d       = lane_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    wb_alu_d     = MEM_alu_data;
    wb_ld_d      = '0;
    wb_pc_d      = MEM_pc_four;
    wb_rd_addr_d = MEM_rd_addr;
    wb_rd_wren_d = 1'b0;
    wb_wb_en_d   = MEM_wb_en;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (op == OP_NONE) begin
          wb_rd_wren_d = MEM_rd_wren;
        end else if (misaligned) begin
          misalign_d = 1'b1;
        end else begin
          stall   = 1'b1;
          state_d = BUS;
          cnt_d   = '0;
          op_d    = op;
          lane_d  = MEM_alu_data[1:0];
          req_d   = 1'b1;
          we_d    = lsu_is_store(op);
          addr_d  = {MEM_alu_data[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
        end
      end
      BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_ack_i || timeout) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
          if (dmem_ack_i) begin
            wb_rd_wren_d = MEM_rd_wren;
            wb_ld_d      = ld_fmt;
          end else begin
            bus_err_d = 1'b1;
          end
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= OP_NONE;
      lane_q       <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      wb_alu_q     <= '0;
      wb_ld_q      <= '0;
      wb_pc_q      <= '0;
      wb_rd_addr_q <= '0;
      wb_rd_wren_q <= 1'b0;
      wb_wb_en_q   <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      wb_alu_q     <= wb_alu_d;
      wb_ld_q      <= wb_ld_d;
      wb_pc_q      <= wb_pc_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_wren_q <= wb_rd_wren_d;
      wb_wb_en_q   <= wb_wb_en_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign MEM_stall_o  = stall & ~rst_i;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign WB_alu_data  = wb_alu_q;
  assign WB_ld_data   = wb_ld_q;
  assign WB_pc_four   = wb_pc_q;
  assign WB_rd_addr   = wb_rd_addr_q;
  assign WB_rd_wren   = wb_rd_wren_q;
  assign WB_wb_en     = wb_wb_en_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule
